// File: rtl/ram_arb_pkg.sv
// Shared types and constants for the two-master RAM port arbiter.
package ram_arb_pkg;
    typedef enum logic {
        IDLE    = 1'b0,
        RD_WAIT = 1'b1
    } arb_state_e;

    localparam logic M0_IDX = 1'b0;
    localparam logic M1_IDX = 1'b1;

    localparam int AW_DEF = 12;
    localparam int DW_DEF = 32;

    function automatic int be_width(input int dw);
        return dw / 8;
    endfunction
endpackage

// File: rtl/ram_bus_arbiter_if.sv
// Bundles both master request/response buses and the RAM port; slave = arbiter view.
interface ram_bus_arbiter_if
    import ram_arb_pkg::*;
#(
    parameter int AW = AW_DEF,
    parameter int DW = DW_DEF
);
    localparam int BW = be_width(DW);

    logic          m0_req, m0_we, m0_gnt, m0_rvalid;
    logic [AW-1:0] m0_addr;
    logic [DW-1:0] m0_wdata, m0_rdata;
    logic [BW-1:0] m0_be;

    logic          m1_req, m1_we, m1_gnt, m1_rvalid, m1_lock;
    logic [AW-1:0] m1_addr;
    logic [DW-1:0] m1_wdata, m1_rdata;
    logic [BW-1:0] m1_be;

    logic          mem_en, mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata, mem_rdata;
    logic [BW-1:0] mem_be;

    modport slave (
        input  m0_req, m0_we, m0_addr, m0_wdata, m0_be,
        output m0_gnt, m0_rvalid, m0_rdata,
        input  m1_req, m1_we, m1_addr, m1_wdata, m1_be, m1_lock,
        output m1_gnt, m1_rvalid, m1_rdata,
        output mem_en, mem_we, mem_addr, mem_wdata, mem_be,
        input  mem_rdata
    );

    modport master (
        output m0_req, m0_we, m0_addr, m0_wdata, m0_be,
        input  m0_gnt, m0_rvalid, m0_rdata,
        output m1_req, m1_we, m1_addr, m1_wdata, m1_be, m1_lock,
        input  m1_gnt, m1_rvalid, m1_rdata,
        input  mem_en, mem_we, mem_addr, mem_wdata, mem_be,
        output mem_rdata
    );
endinterface

// File: rtl/ram_bus_arbiter_pick2.sv
// Combinational 2-way picker; ARB_ROUND_ROBIN_EN selects alternating ties, else M0 wins ties.
module arb_pick2
    import ram_arb_pkg::*;
(
    input  logic req0_i,
    input  logic req1_i,
    input  logic last_i,
    input  logic lock_i,
    output logic gnt0_o,
    output logic gnt1_o
);
    logic pick1;

`ifdef ARB_ROUND_ROBIN_EN
    assign pick1 = req1_i && (!req0_i || (last_i == M0_IDX));
`else
    logic unused_last;
    assign unused_last = last_i;
    assign pick1       = req1_i && !req0_i;
`endif

    // A held lock shuts M0 out completely, even when M1 is not requesting.
    assign gnt1_o = lock_i ? req1_i : pick1;
    assign gnt0_o = !lock_i && req0_i && !pick1;
endmodule

// File: rtl/ram_bus_arbiter.sv
// Shares one synchronous-read RAM port between M0 (LSU) and M1 (DMA, lockable for bursts).
// Tie policy set by macro ARB_ROUND_ROBIN_EN (defined: alternate, undefined: M0 priority).
module ram_bus_arbiter
    import ram_arb_pkg::*;
#(
    parameter int AW = AW_DEF,
    parameter int DW = DW_DEF
) (
    input  logic               clk,
    input  logic               rst,
    ram_bus_arbiter_if.slave   bus
);
    localparam int BW = be_width(DW);

    arb_state_e    state_q;
    logic          owner_q, lock_q, last_q;
    logic          m0_rvalid_q, m1_rvalid_q;

    logic          idle, gnt0, gnt1, win_we;
    logic [AW-1:0] win_addr;
    logic [DW-1:0] win_wdata;
    logic [BW-1:0] win_be;

    // Grants are combinational, so gate them with rst to keep outputs quiet in reset.
    assign idle = (state_q == IDLE) && !rst;

    arb_pick2 u_pick (
        .req0_i (bus.m0_req && idle),
        .req1_i (bus.m1_req && idle),
        .last_i (last_q),
        .lock_i (lock_q),
        .gnt0_o (gnt0),
        .gnt1_o (gnt1)
    );

    assign win_we    = gnt1 ? bus.m1_we    : (gnt0 ? bus.m0_we    : 1'b0);
    assign win_addr  = gnt1 ? bus.m1_addr  : (gnt0 ? bus.m0_addr  : '0);
    assign win_wdata = gnt1 ? bus.m1_wdata : (gnt0 ? bus.m0_wdata : '0);
    assign win_be    = gnt1 ? bus.m1_be    : (gnt0 ? bus.m0_be    : '0);

    assign bus.m0_gnt    = gnt0;
    assign bus.m1_gnt    = gnt1;
    assign bus.mem_en    = gnt0 || gnt1;
    assign bus.mem_we    = win_we;
    assign bus.mem_addr  = win_addr;
    assign bus.mem_wdata = win_wdata;
    assign bus.mem_be    = win_be;

    assign bus.m0_rvalid = m0_rvalid_q;
    assign bus.m1_rvalid = m1_rvalid_q;
    assign bus.m0_rdata  = (state_q == RD_WAIT && owner_q == M0_IDX) ? bus.mem_rdata : '0;
    assign bus.m1_rdata  = (state_q == RD_WAIT && owner_q == M1_IDX) ? bus.mem_rdata : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            owner_q     <= M0_IDX;
            lock_q      <= 1'b0;
            last_q      <= M1_IDX;
            m0_rvalid_q <= 1'b0;
            m1_rvalid_q <= 1'b0;
        end else begin
            m0_rvalid_q <= 1'b0;
            m1_rvalid_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (gnt0 || gnt1) begin
                        last_q <= gnt1;
                        if (!win_we) begin
                            owner_q     <= gnt1;
                            state_q     <= RD_WAIT;
                            m0_rvalid_q <= gnt0;
                            m1_rvalid_q <= gnt1;
                        end
                    end
                end
                RD_WAIT: state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
            if (state_q == IDLE && !bus.m1_lock)
                lock_q <= 1'b0;
            else if (gnt1 && bus.m1_lock)
                lock_q <= 1'b1;
        end
    end
endmodule

// File: tb/tb_ram_bus_arbiter.sv
// Directed bench for ram_bus_arbiter with a behavioural 1-cycle-latency RAM behind it.
module tb_ram_bus_arbiter;
    logic clk = 1'b0;
    logic rst;
    int   vectors     = 0;
    int   miscompares = 0;

    always #5 clk = ~clk;

    ram_bus_arbiter_if #(.AW(12), .DW(32)) bus ();

    ram_bus_arbiter #(.AW(12), .DW(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    logic [31:0] ram [0:4095];
    logic [31:0] ram_rdata = '0;

    always @(posedge clk) begin
        if (bus.mem_en) begin
            if (bus.mem_we) begin
                for (int b = 0; b < 4; b++)
                    if (bus.mem_be[b]) ram[bus.mem_addr][8*b +: 8] <= bus.mem_wdata[8*b +: 8];
            end else begin
                ram_rdata <= ram[bus.mem_addr];
            end
        end
    end
    assign bus.mem_rdata = ram_rdata;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic set0(input logic req, input logic we, input logic [11:0] addr,
                        input logic [31:0] wdata, input logic [3:0] be);
        bus.m0_req = req; bus.m0_we = we; bus.m0_addr = addr;
        bus.m0_wdata = wdata; bus.m0_be = be;
    endtask

    task automatic set1(input logic req, input logic we, input logic lock, input logic [11:0] addr,
                        input logic [31:0] wdata, input logic [3:0] be);
        bus.m1_req = req; bus.m1_we = we; bus.m1_lock = lock; bus.m1_addr = addr;
        bus.m1_wdata = wdata; bus.m1_be = be;
    endtask

    logic exp1;

    initial begin
        // Reset: requests held high must not produce grants or strobes.
        rst = 1'b1;
        set0(1, 0, 12'h000, 32'h0, 4'h0);
        set1(1, 0, 0, 12'h000, 32'h0, 4'h0);
        #2;
        chk("rst_m0_gnt", {31'd0, bus.m0_gnt}, 32'd0);
        chk("rst_m1_gnt", {31'd0, bus.m1_gnt}, 32'd0);
        chk("rst_mem_en", {31'd0, bus.mem_en}, 32'd0);
        chk("rst_rvalid", {30'd0, bus.m1_rvalid, bus.m0_rvalid}, 32'd0);
        cyc();
        set0(0, 0, 12'h000, 32'h0, 4'h0);
        set1(0, 0, 0, 12'h000, 32'h0, 4'h0);
        cyc();
        rst = 1'b0;

        // Seed 0x010 then read it back alone.
        set0(1, 1, 12'h010, 32'hDEADBEEF, 4'hF);
        #1;
        chk("wr_m0_gnt", {31'd0, bus.m0_gnt}, 32'd1);
        chk("wr_mem_we", {31'd0, bus.mem_we}, 32'd1);
        chk("wr_mem_wdata", bus.mem_wdata, 32'hDEADBEEF);
        cyc();
        set0(1, 0, 12'h010, 32'h0, 4'h0);
        #1;
        chk("rd1_m0_gnt", {31'd0, bus.m0_gnt}, 32'd1);
        chk("rd1_mem_addr", {20'd0, bus.mem_addr}, 32'h010);
        chk("rd1_rvalid_T", {31'd0, bus.m0_rvalid}, 32'd0);
        cyc();
        set0(0, 0, 12'h000, 32'h0, 4'h0);
        #1;
        chk("rd1_rvalid_T1", {31'd0, bus.m0_rvalid}, 32'd1);
        chk("rd1_rdata", bus.m0_rdata, 32'hDEADBEEF);
        chk("rd1_m1_rvalid", {31'd0, bus.m1_rvalid}, 32'd0);
        chk("rd1_m1_rdata", bus.m1_rdata, 32'h0);
        cyc();
        chk("rd1_rvalid_T2", {31'd0, bus.m0_rvalid}, 32'd0);

        // Both masters write every cycle; last grant was M0.
        for (int k = 0; k < 4; k++) begin
            set0(1, 1, 12'h030, 32'h30000000 + k, 4'hF);
            set1(1, 1, 0, 12'h031, 32'h31000000 + k, 4'hF);
            #1;
`ifdef ARB_ROUND_ROBIN_EN
            exp1 = (k % 2 == 0);
`else
            exp1 = 1'b0;
`endif
            chk("wr2_m0_gnt", {31'd0, bus.m0_gnt}, {31'd0, !exp1});
            chk("wr2_m1_gnt", {31'd0, bus.m1_gnt}, {31'd0, exp1});
            chk("wr2_mem_en", {31'd0, bus.mem_en}, 32'd1);
            cyc();
        end
        set0(0, 0, 12'h000, 32'h0, 4'h0);
        #1;
        chk("wr2_m1_alone", {31'd0, bus.m1_gnt}, 32'd1);
        chk("wr2_m1_addr", {20'd0, bus.mem_addr}, 32'h031);
        cyc();
        set1(0, 0, 0, 12'h000, 32'h0, 4'h0);

        // M1 locked burst of 4 writes; M0 read pending from the second beat.
        for (int k = 0; k < 4; k++) begin
            set1(1, 1, 1, 12'h100 + k, 32'hA0000000 + k, 4'hF);
            if (k > 0) set0(1, 0, 12'h101, 32'h0, 4'h0);
            #1;
            chk("lk_m1_gnt", {31'd0, bus.m1_gnt}, 32'd1);
            chk("lk_m0_gnt", {31'd0, bus.m0_gnt}, 32'd0);
            cyc();
        end
        set1(0, 0, 1, 12'h000, 32'h0, 4'h0);
        #1;
        chk("lk_hold_m0_gnt", {31'd0, bus.m0_gnt}, 32'd0);
        chk("lk_hold_mem_en", {31'd0, bus.mem_en}, 32'd0);
        cyc();
        bus.m1_lock = 1'b0;
        #1;
        chk("lk_fall_m0_gnt", {31'd0, bus.m0_gnt}, 32'd0);
        cyc();
        chk("lk_after_m0_gnt", {31'd0, bus.m0_gnt}, 32'd1);
        chk("lk_after_we", {31'd0, bus.mem_we}, 32'd0);
        cyc();
        set0(0, 0, 12'h000, 32'h0, 4'h0);
        #1;
        chk("lk_rd_rvalid", {31'd0, bus.m0_rvalid}, 32'd1);
        chk("lk_rd_rdata", bus.m0_rdata, 32'hA0000001);
        cyc();

        // Back-to-back reads; seed 0x020 via M0 and 0x021 via M1 so M0 wins the tie.
        set0(1, 1, 12'h020, 32'h20202020, 4'hF);
        cyc();
        set0(0, 0, 12'h000, 32'h0, 4'h0);
        set1(1, 1, 0, 12'h021, 32'h21212121, 4'hF);
        cyc();
        set0(1, 0, 12'h020, 32'h0, 4'h0);
        set1(1, 0, 0, 12'h021, 32'h0, 4'h0);
        #1;
        chk("b2b_T_m0_gnt", {31'd0, bus.m0_gnt}, 32'd1);
        chk("b2b_T_m1_gnt", {31'd0, bus.m1_gnt}, 32'd0);
        cyc();
        set0(0, 0, 12'h000, 32'h0, 4'h0);
        #1;
        chk("b2b_T1_m0_rvalid", {31'd0, bus.m0_rvalid}, 32'd1);
        chk("b2b_T1_m0_rdata", bus.m0_rdata, 32'h20202020);
        chk("b2b_T1_m1_rvalid", {31'd0, bus.m1_rvalid}, 32'd0);
        chk("b2b_T1_m1_rdata", bus.m1_rdata, 32'h0);
        chk("b2b_T1_m1_gnt", {31'd0, bus.m1_gnt}, 32'd0);
        cyc();
        chk("b2b_T2_m1_gnt", {31'd0, bus.m1_gnt}, 32'd1);
        chk("b2b_T2_m0_rvalid", {31'd0, bus.m0_rvalid}, 32'd0);
        cyc();
        set1(0, 0, 0, 12'h000, 32'h0, 4'h0);
        #1;
        chk("b2b_T3_m1_rvalid", {31'd0, bus.m1_rvalid}, 32'd1);
        chk("b2b_T3_m1_rdata", bus.m1_rdata, 32'h21212121);
        chk("b2b_T3_m0_rvalid", {31'd0, bus.m0_rvalid}, 32'd0);
        chk("b2b_T3_m0_rdata", bus.m0_rdata, 32'h0);
        cyc();

        // Reset while M1's read is in RD_WAIT.
        set1(1, 0, 0, 12'h021, 32'h0, 4'h0);
        #1;
        chk("mrst_m1_gnt", {31'd0, bus.m1_gnt}, 32'd1);
        cyc();
        chk("mrst_pre_rvalid", {31'd0, bus.m1_rvalid}, 32'd1);
        rst = 1'b1;
        set0(1, 0, 12'h020, 32'h0, 4'h0);
        #1;
        chk("mrst_m1_rvalid", {31'd0, bus.m1_rvalid}, 32'd0);
        chk("mrst_m1_rdata", bus.m1_rdata, 32'h0);
        chk("mrst_mem_en", {31'd0, bus.mem_en}, 32'd0);
        chk("mrst_gnts", {30'd0, bus.m1_gnt, bus.m0_gnt}, 32'd0);
        cyc();
        rst = 1'b0;
        #1;
        chk("mrst_tie_m0_gnt", {31'd0, bus.m0_gnt}, 32'd1);
        chk("mrst_tie_m1_gnt", {31'd0, bus.m1_gnt}, 32'd0);
        chk("mrst_no_rvalid", {30'd0, bus.m1_rvalid, bus.m0_rvalid}, 32'd0);
        cyc();
        set0(0, 0, 12'h000, 32'h0, 4'h0);
        set1(0, 0, 0, 12'h000, 32'h0, 4'h0);
        #1;
        chk("mrst_m0_rvalid", {31'd0, bus.m0_rvalid}, 32'd1);
        chk("mrst_m0_rdata", bus.m0_rdata, 32'h20202020);
        chk("mrst_m1_rvalid2", {31'd0, bus.m1_rvalid}, 32'd0);
        cyc();

        // Single-byte write merge.
        set0(1, 1, 12'h050, 32'h11223344, 4'hF);
        cyc();
        set0(1, 1, 12'h050, 32'h0000AB00, 4'b0010);
        #1;
        chk("be_mem_be", {28'd0, bus.mem_be}, 32'h2);
        cyc();
        set0(1, 0, 12'h050, 32'h0, 4'h0);
        cyc();
        set0(0, 0, 12'h000, 32'h0, 4'h0);
        #1;
        chk("be_rvalid", {31'd0, bus.m0_rvalid}, 32'd1);
        chk("be_rdata", bus.m0_rdata, 32'h1122AB44);
        cyc();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
